// File: rtl/rx_bit_packer.sv
// rx_bit_packer
//   Takes the serial descrambled bit stream from the receive decode chain,
//   optionally drops the leading SERVICE bits of every frame, and packs the
//   rest LSB-first into bytes. Each byte is presented through a registered
//   valid/ready output together with last, the symbol tag and the index of
//   the byte within its frame.
//
//   Build option: define RX_PACK_SVC_STRIP_EN to build the SERVICE stripper.
//   When it is undefined, every bit is packed and err_short is tied to 0.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   din             descrambled data bit
//   din_vld/rdy     input handshake
//   din_last        final bit of the frame
//   din_symb_cnt    OFDM symbol index of din
//   dout            packed byte, first received bit in dout[0]
//   dout_vld/rdy    output handshake
//   dout_last       final byte of the frame
//   dout_nbits      number of valid bits in dout (1..8)
//   dout_symb_cnt   symbol index of the bit that completed the byte
//   dout_idx        0-based byte index within the frame, saturating
//   err_short       one-cycle pulse: frame ended inside the SERVICE field
module rx_bit_packer #(
  parameter int SVC_BITS = 16,
  parameter int IDX_W    = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_vld,
  output logic             din_rdy,
  input  logic             din_last,
  input  logic [7:0]       din_symb_cnt,
  output logic [7:0]       dout,
  output logic             dout_vld,
  input  logic             dout_rdy,
  output logic             dout_last,
  output logic [3:0]       dout_nbits,
  output logic [7:0]       dout_symb_cnt,
  output logic [IDX_W-1:0] dout_idx,
  output logic             err_short
);

  // state  | meaning
  // S_SVC  | discarding SERVICE bits of the current frame
  // S_PACK | packing data bits into bytes
`ifdef RX_PACK_SVC_STRIP_EN
  typedef enum logic [0:0] {S_SVC = 1'b0, S_PACK = 1'b1} state_t;
  localparam state_t S_RESET = S_SVC;
`else
  typedef enum logic [0:0] {S_PACK = 1'b0} state_t;
  localparam state_t S_RESET = S_PACK;
`endif

  state_t           state_q, state_d;
  logic [7:0]       shreg_q;
  logic [2:0]       bit_cnt_q;
  logic [IDX_W-1:0] byte_cnt_q;
  logic             acc;
  logic             pack_bit;
  logic             byte_done;
  logic             short_d;
  logic [7:0]       byte_val;

`ifdef RX_PACK_SVC_STRIP_EN
  logic [4:0] svc_cnt_q;
  logic       svc_inc;
  logic       svc_clr;

  // SERVICE bits are always accepted; they never touch the output register.
  assign din_rdy = (state_q == S_SVC) || !dout_vld || dout_rdy;
`else
  // SVC_BITS only matters when the stripper is built.
  logic [31:0] unused_svc_bits;
  assign unused_svc_bits = SVC_BITS;

  assign din_rdy = !dout_vld || dout_rdy;
`endif

  assign acc      = din_vld && din_rdy;
  // Positions above bit_cnt are still 0, so OR-ing in the new bit leaves
  // unused upper bits cleared for a short final byte.
  assign byte_val = shreg_q | (8'(din) << bit_cnt_q);

  always_comb begin
    state_d   = state_q;
    pack_bit  = 1'b0;
    byte_done = 1'b0;
    short_d   = 1'b0;
`ifdef RX_PACK_SVC_STRIP_EN
    svc_inc   = 1'b0;
    svc_clr   = 1'b0;
`endif
    case (state_q)
`ifdef RX_PACK_SVC_STRIP_EN
      S_SVC: begin
        if (acc) begin
          // A frame ending in the SERVICE field wins over entering S_PACK.
          if (din_last) begin
            short_d = 1'b1;
            svc_clr = 1'b1;
          end else if (svc_cnt_q == 5'(SVC_BITS - 1)) begin
            state_d = S_PACK;
            svc_clr = 1'b1;
          end else begin
            svc_inc = 1'b1;
          end
        end
      end
`endif
      S_PACK: begin
        if (acc) begin
          pack_bit = 1'b1;
          if (bit_cnt_q == 3'd7 || din_last) byte_done = 1'b1;
`ifdef RX_PACK_SVC_STRIP_EN
          if (din_last) state_d = S_SVC;
`endif
        end
      end
      default: state_d = S_RESET;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_RESET;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef RX_PACK_SVC_STRIP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      svc_cnt_q <= '0;
    end else if (svc_clr) begin
      svc_cnt_q <= '0;
    end else if (svc_inc) begin
      svc_cnt_q <= svc_cnt_q + 5'd1;
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg_q       <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      dout          <= '0;
      dout_vld      <= 1'b0;
      dout_last     <= 1'b0;
      dout_nbits    <= '0;
      dout_symb_cnt <= '0;
      dout_idx      <= '0;
      err_short     <= 1'b0;
    end else begin
      err_short <= short_d;

      if (dout_vld && dout_rdy) dout_vld <= 1'b0;

      // byte_done only happens when din_rdy is high, so a held byte is
      // never overwritten.
      if (byte_done) begin
        dout          <= byte_val;
        dout_vld      <= 1'b1;
        dout_last     <= din_last;
        dout_nbits    <= 4'({1'b0, bit_cnt_q}) + 4'd1;
        dout_symb_cnt <= din_symb_cnt;
        dout_idx      <= byte_cnt_q;
      end

      if (pack_bit) begin
        if (byte_done) begin
          shreg_q   <= '0;
          bit_cnt_q <= '0;
        end else begin
          shreg_q   <= byte_val;
          bit_cnt_q <= bit_cnt_q + 3'd1;
        end
      end

      if (byte_done) begin
        if (din_last) begin
          byte_cnt_q <= '0;
        end else if (byte_cnt_q != {IDX_W{1'b1}}) begin
          byte_cnt_q <= byte_cnt_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rx_bit_packer.sv
module tb_rx_bit_packer;

  localparam int IDX_W = 3;

  typedef struct packed {
    logic [7:0]       data;
    logic [3:0]       nbits;
    logic             last;
    logic [7:0]       symb;
    logic [IDX_W-1:0] idx;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             din = 1'b0;
  logic             din_vld = 1'b0;
  logic             din_rdy;
  logic             din_last = 1'b0;
  logic [7:0]       din_symb_cnt = 8'h00;
  logic [7:0]       dout;
  logic             dout_vld;
  logic             dout_rdy = 1'b1;
  logic             dout_last;
  logic [3:0]       dout_nbits;
  logic [7:0]       dout_symb_cnt;
  logic [IDX_W-1:0] dout_idx;
  logic             err_short;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   stall = 0;
  int   stall_waits = 0;
  int   short_cnt = 0;
  int   exp_short = 0;

  rx_bit_packer #(.SVC_BITS(16), .IDX_W(IDX_W)) dut (
    .clk(clk), .rst(rst),
    .din(din), .din_vld(din_vld), .din_rdy(din_rdy), .din_last(din_last),
    .din_symb_cnt(din_symb_cnt),
    .dout(dout), .dout_vld(dout_vld), .dout_rdy(dout_rdy), .dout_last(dout_last),
    .dout_nbits(dout_nbits), .dout_symb_cnt(dout_symb_cnt), .dout_idx(dout_idx),
    .err_short(err_short)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (stall > 0) begin
      dout_rdy = 1'b0;
      stall--;
    end else begin
      dout_rdy = 1'b1;
    end
  end

  // Monitor: samples mid-cycle, after all drivers have settled.
  always @(negedge clk) begin
    exp_t e;
    exp_t a;
    #2;
    if (err_short) short_cnt++;
    if (dout_vld && dout_rdy) begin
      a = '{dout, dout_nbits, dout_last, dout_symb_cnt, dout_idx};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_byte: got data=%h nbits=%0d last=%0d symb=%h idx=%0d, expected no byte",
                 a.data, a.nbits, a.last, a.symb, a.idx);
      end else begin
        e = exp_q.pop_front();
        if (a !== e) begin
          errors++;
          $display("FAIL byte: got data=%h nbits=%0d last=%0d symb=%h idx=%0d, expected data=%h nbits=%0d last=%0d symb=%h idx=%0d",
                   a.data, a.nbits, a.last, a.symb, a.idx, e.data, e.nbits, e.last, e.symb, e.idx);
        end
      end
    end
  end

  task automatic check(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  task automatic push_exp(input logic [7:0] d, input logic [3:0] nb, input logic l,
                          input logic [7:0] s, input logic [IDX_W-1:0] idx);
    exp_q.push_back('{d, nb, l, s, idx});
  endtask

  // Called at a negedge; returns at the negedge after the bit was accepted.
  task automatic send_bit(input logic b, input logic l, input logic [7:0] s);
    bit done = 0;
    din = b; din_last = l; din_symb_cnt = s; din_vld = 1'b1;
    for (int t = 0; t < 200 && !done; t++) begin
      #2;
      if (din_rdy) done = 1;
      else stall_waits++;
      @(negedge clk);
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL din_accept_timeout: din_rdy stayed 0, expected 1 within 200 cycles");
    end
    din_vld = 1'b0; din_last = 1'b0; din = 1'b0;
  endtask

  task automatic send_bits(input logic [31:0] bits, input int n, input bit last_end,
                           input logic [7:0] symb0, input int symb_div);
    for (int i = 0; i < n; i++)
      send_bit(bits[i], last_end && (i == n - 1), symb0 + 8'(i / symb_div));
  endtask

  task automatic svc_prefix();
`ifdef RX_PACK_SVC_STRIP_EN
    send_bits(32'h0000_F00F, 16, 0, 8'hEE, 1);
`endif
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int w;
    logic [7:0] v;
    repeat (3) @(negedge clk);
    #2;
    check("reset_dout", dout, 0);
    check("reset_dout_vld", dout_vld, 0);
    check("reset_dout_last", dout_last, 0);
    check("reset_dout_nbits", dout_nbits, 0);
    check("reset_dout_symb", dout_symb_cnt, 0);
    check("reset_dout_idx", dout_idx, 0);
    check("reset_err_short", err_short, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #2;
    check("idle_din_rdy", din_rdy, 1);
    @(negedge clk);

    // 0xA5, 0x3C with last on final bit, no backpressure.
    w = stall_waits;
    svc_prefix();
    push_exp(8'hA5, 4'd8, 1'b0, 8'h11, 3'd0);
    push_exp(8'h3C, 4'd8, 1'b1, 8'h13, 3'd1);
    send_bits(32'h0000_3CA5, 16, 1, 8'h10, 4);
    check("din_rdy_high_throughout", stall_waits - w, 0);

    // 11 data bits: 1,0,1,1,0,0,0,0,1,1,1 -> 0x0D then 0x07 (3 bits).
    svc_prefix();
    push_exp(8'h0D, 4'd8, 1'b0, 8'h20, 3'd0);
    push_exp(8'h07, 4'd3, 1'b1, 8'h20, 3'd1);
    send_bits(32'h0000_070D, 11, 1, 8'h20, 100);

    // Last on the very first data bit.
    svc_prefix();
    push_exp(8'h01, 4'd1, 1'b1, 8'h21, 3'd0);
    send_bits(32'h1, 1, 1, 8'h21, 1);

    // Backpressure: 20-cycle stall while streaming three bytes.
    svc_prefix();
    w = stall_waits;
    stall = 20;
    push_exp(8'h12, 4'd8, 1'b0, 8'h30, 3'd0);
    push_exp(8'h34, 4'd8, 1'b0, 8'h31, 3'd1);
    push_exp(8'h56, 4'd8, 1'b1, 8'h32, 3'd2);
    send_bits(32'h0056_3412, 24, 1, 8'h30, 8);
    check("din_rdy_low_when_held", (stall_waits - w) > 0, 1);

    // Byte index saturates at 7 for IDX_W=3.
    svc_prefix();
    for (int k = 0; k < 10; k++) begin
      v = 8'(k * 37 + 3);
      push_exp(v, 4'd8, k == 9, 8'h40, (k > 7) ? 3'd7 : 3'(k));
      send_bits({24'h0, v}, 8, k == 9, 8'h40, 100);
    end

    // Reset mid-frame after one complete byte plus 5 bits.
    svc_prefix();
    push_exp(8'h11, 4'd8, 1'b0, 8'h50, 3'd0);
    send_bits(32'h0000_1F11, 13, 0, 8'h50, 100);
    pulse_rst();
    svc_prefix();
    push_exp(8'h6B, 4'd8, 1'b1, 8'h51, 3'd0);
    send_bits(32'h6B, 8, 1, 8'h51, 100);

`ifdef RX_PACK_SVC_STRIP_EN
    // 10-bit frame ends inside SERVICE; then next frame is stripped again.
    send_bits(32'h3FF, 10, 1, 8'h60, 100);
    exp_short++;
    svc_prefix();
    push_exp(8'h81, 4'd8, 1'b1, 8'h61, 3'd0);
    send_bits(32'h81, 8, 1, 8'h61, 100);
    // Frame of exactly 16 SERVICE bits with last on the final one.
    send_bits(32'hFFFF, 16, 1, 8'h62, 100);
    exp_short++;
    svc_prefix();
    push_exp(8'hC3, 4'd8, 1'b1, 8'h63, 3'd0);
    send_bits(32'hC3, 8, 1, 8'h63, 100);
`else
    // Without stripping, the first 8 bits of a frame are a byte.
    push_exp(8'hFF, 4'd8, 1'b1, 8'h70, 3'd0);
    send_bits(32'hFF, 8, 1, 8'h70, 100);
`endif

    repeat (10) @(negedge clk);
    check("scoreboard_drained", exp_q.size(), 0);
    check("err_short_pulses", short_cnt, exp_short);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
